instr_mem_readback: RTL and testbench
=====================================

Name: instr_mem_readback

Overview:
- Read-side companion to the instruction-programming state machine.
- After a program has been written into instruction memory, this block reads words 0..num_instr-1 back through the memory's read port and compares each word against the expected program word supplied by the same program table.
- It reports pass/fail, the mismatch count, the first failing address and a rolling checksum, so a board or bench can confirm the write sequence before the computer is released to run.

Parameters:
- ADDR_W, 7, instruction-memory address width.
- DATA_W, 32, instruction word width.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a readback; sampled on posedge clk.
- num_instr  input  ADDR_W+1  number of words to check (0..2^ADDR_W); sampled on the start cycle.
- rd_en  output  1  read strobe to instruction memory (registered).
- rd_addr  output  ADDR_W  read address (registered).
- rd_data  input  DATA_W  memory read data; valid the cycle after rd_en.
- exp_addr  output  ADDR_W  address whose expected word is requested (registered); drives the program table index.
- exp_instr  input  DATA_W  expected word for exp_addr; combinational from the program table.
- busy  output  1  high in READ and DRAIN.
- done  output  1  high in DONE.
- pass  output  1  done and mismatch_count == 0.
- mismatch_count  output  ADDR_W+1  number of compare failures.
- first_bad_addr  output  ADDR_W  address of the first mismatch; 0 if none.
- checksum  output  DATA_W  rolling checksum of the words read.

Behaviour:
- Reset (async, rst=1): state=IDLE, every output 0, internal count and length registers 0. Takes effect immediately, including mid-READ or mid-DRAIN; an aborted run leaves no partial results visible.
- States and transitions:
  - IDLE: start=1 latches N=num_instr and clears the statistics. Next state is READ, or DONE if N=0.
  - READ: rd_en=1. rd_addr steps 0,1,...,N-1, one per cycle. After the cycle that issues address N-1, next state is DRAIN.
  - DRAIN: rd_en=0. Performs the final compare. Next state is DONE.
  - DONE: done=1. pass is valid. Results hold until start or rst. start in DONE behaves exactly as start in IDLE (clears results, restarts).
- start while busy is ignored; it neither restarts nor extends the run.
- Pipeline: while rd_addr=a is issued in cycle k, exp_addr=a is presented in cycle k+1. At the end of cycle k+1 the block samples rd_data and exp_instr and performs:
  - compare: if rd_data != exp_instr, mismatch_count += 1; if this is the first mismatch of the run, first_bad_addr = a.
  - checksum update: checksum <= {checksum[DATA_W-2:0], checksum[DATA_W-1]} ^ rd_data, i.e. rotate-left-1 then XOR.
- A compare happens only in cycles that follow an rd_en=1 cycle; no compare occurs in IDLE or DONE.
- Latency: with the start edge at t0, rd_en is high for cycles 1..N, DRAIN is cycle N+1, and done=1 from cycle N+2. For N=0, done=1 in cycle 1, pass=1, checksum=0.
- N=2^ADDR_W (128): the address counter must not wrap before the last read. The final address is 127, then DRAIN. No read at address 0 may be repeated.
- mismatch_count cannot overflow because its width is ADDR_W+1 and N ≤ 2^ADDR_W.
- pass and done are registered and change in the same cycle.
- exp_addr holds its last value outside READ/DRAIN and returns to 0 on start.
- The block only reads; it never drives write enables. It must not be run concurrently with the writer (system sequencing guarantees this).

Test Plan:
- Reset behaviour: reset, then start with N=3 where memory and table both hold 0x1, 0x2, 0x4 -> rd_en high for exactly 3 cycles with addresses 0, 1, 2; done in cycle 5; pass=1; mismatch_count=0; checksum=0x00000004.
- Mismatch detection: N=27 with the table equal to memory except memory[14]=0x00000000 and memory[20]=0xFFFFFFFF -> mismatch_count=2, first_bad_addr=14, pass=0, done=1.
- Zero length: N=0 -> no rd_en pulse; done=1 and pass=1 one cycle after start; checksum=0.
- Full depth: N=128 with an all-matching memory -> rd_addr covers 0..127 once each, done in cycle 130, pass=1. The checksum must equal a software rotate-XOR model computed over the 128 words.
- Overlapping start and restart: pulse start again at cycle 3 of an N=10 run -> ignored, done in cycle 12. Then pulse start in DONE with N=2 -> results clear, new run completes with done in cycle 4 relative to that start.
- Async reset mid-run: assert rst at cycle 5 of an N=20 run, without a clock edge -> all outputs 0 immediately. A subsequent start with N=1 completes normally with done in cycle 3.

Source files
------------

// File: rtl/instr_mem_readback.sv
// Instruction-memory readback checker: reads words 0..N-1 back through the
// memory read port, compares each against the program table, and reports
// pass/fail, mismatch count, first failing address and a rotate-XOR checksum.
module instr_mem_readback #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_instr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_instr,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   mismatch_count,
  output logic [ADDR_W-1:0] first_bad_addr,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   issued;
  logic              vld_p1;
  logic              start_acc;
  logic              miss;
  logic [ADDR_W:0]   cnt_nxt;
  logic              enter_done;

  // Rotate left by one, then fold in the new word.
  function automatic logic [DATA_W-1:0] rot_xor(input logic [DATA_W-1:0] c,
                                                input logic [DATA_W-1:0] d);
    return {c[DATA_W-2:0], c[DATA_W-1]} ^ d;
  endfunction

  // A start is honoured only when no run is in flight.
  assign start_acc  = start && ((state == S_IDLE) || (state == S_DONE));
  assign miss       = vld_p1 && (rd_data != exp_instr);
  assign cnt_nxt    = start_acc ? '0 : mismatch_count + {{ADDR_W{1'b0}}, miss};
  assign enter_done = (state_nxt == S_DONE) && ((state != S_DONE) || start_acc);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; READ ends once the last address has been issued.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = (num_instr == '0) ? S_DONE : S_READ;
      S_READ:         if (issued == len) state_nxt = S_DRAIN;
      S_DRAIN:        state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Read address generation and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len     <= '0;
      issued  <= '0;
      rd_addr <= '0;
      rd_en   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (start_acc) begin
        len     <= num_instr;
        issued  <= (num_instr != '0) ? {{ADDR_W{1'b0}}, 1'b1} : '0;
        rd_addr <= '0;
      end else if ((state == S_READ) && (state_nxt == S_READ)) begin
        issued  <= issued + 1'b1;
        rd_addr <= rd_addr + 1'b1;
      end
      rd_en <= (state_nxt == S_READ);
      busy  <= (state_nxt == S_READ) || (state_nxt == S_DRAIN);
      done  <= (state_nxt == S_DONE);
    end
  end

  // Compare stage: one cycle behind the read strobe, aligned with rd_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1         <= 1'b0;
      exp_addr       <= '0;
      mismatch_count <= '0;
      first_bad_addr <= '0;
      checksum       <= '0;
      pass           <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en)          exp_addr <= rd_addr;
      else if (start_acc) exp_addr <= '0;
      if (start_acc) begin
        checksum       <= '0;
        first_bad_addr <= '0;
      end else if (vld_p1) begin
        checksum <= rot_xor(checksum, rd_data);
        if (miss && (mismatch_count == '0)) first_bad_addr <= exp_addr;
      end
      mismatch_count <= cnt_nxt;
      if (enter_done)     pass <= (cnt_nxt == '0);
      else if (start_acc) pass <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_readback.sv
// Randomized self-checking bench for instr_mem_readback against a loop-based
// reference computed from the memory and program-table arrays.
module tb_instr_mem_readback;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   num_instr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_instr;
  logic              busy, done, pass;
  logic [ADDR_W:0]   mismatch_count;
  logic [ADDR_W-1:0] first_bad_addr;
  logic [DATA_W-1:0] checksum;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] tbl [DEPTH];
  int                log_q [$];
  int                errors = 0;
  int                checks = 0;

  instr_mem_readback #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_instr(num_instr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .exp_addr(exp_addr), .exp_instr(exp_instr),
    .busy(busy), .done(done), .pass(pass),
    .mismatch_count(mismatch_count), .first_bad_addr(first_bad_addr),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory and combinational program table.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
  assign exp_instr = tbl[exp_addr];

  // Record every issued read address.
  always @(negedge clk) if (rd_en) log_q.push_back(int'(rd_addr));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_match();
    for (int i = 0; i < DEPTH; i++) begin
      tbl[i] = $urandom;
      mem[i] = tbl[i];
    end
  endtask

  task automatic run_check(input int n, input int poke_cyc);
    int               cyc;
    int               exp_cnt;
    int               exp_first;
    int               bad;
    logic [DATA_W-1:0] exp_cs;
    exp_cnt = 0; exp_first = 0; exp_cs = '0;
    for (int i = 0; i < n; i++) begin
      if (mem[i] != tbl[i]) begin
        if (exp_cnt == 0) exp_first = i;
        exp_cnt++;
      end
      exp_cs = {exp_cs[DATA_W-2:0], exp_cs[DATA_W-1]} ^ mem[i];
    end
    @(negedge clk);
    start = 1'b1;
    num_instr = n[ADDR_W:0];
    log_q.delete();
    @(negedge clk);
    start = 1'b0;
    num_instr = ADDR_W'($urandom);
    cyc = 1;
    chk("clr_cnt", 64'(mismatch_count), 64'd0);
    chk("clr_cs", 64'(checksum), 64'd0);
    chk("busy_c1", 64'(busy), 64'(n != 0));
    while (!done && cyc < 400) begin
      if (cyc == poke_cyc) begin
        start = 1'b1;
        num_instr = 8'd5;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    chk("done_cyc", 64'(cyc), 64'((n == 0) ? 1 : n + 2));
    chk("pass", 64'(pass), 64'(exp_cnt == 0));
    chk("mis_cnt", 64'(mismatch_count), 64'(exp_cnt));
    chk("first_bad", 64'(first_bad_addr), 64'(exp_first));
    chk("checksum", 64'(checksum), 64'(exp_cs));
    chk("rd_cycles", 64'(log_q.size()), 64'(n));
    bad = 0;
    foreach (log_q[i]) if (log_q[i] != i) bad++;
    chk("addr_seq", 64'(bad), 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; num_instr = '0;
    fill_match();
    repeat (3) @(negedge clk);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    // Three-word program with a known checksum.
    mem[0] = 32'h1; mem[1] = 32'h2; mem[2] = 32'h4;
    tbl[0] = 32'h1; tbl[1] = 32'h2; tbl[2] = 32'h4;
    run_check(3, 0);
    chk("cs_lit", 64'(checksum), 64'h4);

    // Two corrupted words.
    fill_match();
    mem[14] = 32'h0;        if (tbl[14] == 32'h0)        tbl[14] = 32'h1;
    mem[20] = 32'hFFFFFFFF; if (tbl[20] == 32'hFFFFFFFF) tbl[20] = 32'h0;
    run_check(27, 0);
    chk("mis_lit", 64'(mismatch_count), 64'd2);
    chk("first_lit", 64'(first_bad_addr), 64'd14);

    // Zero length, then full depth.
    run_check(0, 0);
    fill_match();
    run_check(128, 0);

    // Start while busy is ignored; start in DONE restarts.
    fill_match();
    mem[7] = ~tbl[7];
    run_check(10, 3);
    fill_match();
    run_check(2, 0);

    // Asynchronous reset between clock edges mid-run.
    @(negedge clk);
    start = 1'b1; num_instr = 8'd20;
    mem[1] = ~tbl[1];
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_rd_en", 64'(rd_en), 64'd0);
    chk("arst_addr", 64'(rd_addr), 64'd0);
    chk("arst_cnt", 64'(mismatch_count), 64'd0);
    chk("arst_cs", 64'(checksum), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    fill_match();
    run_check(1, 0);

    // Random lengths with random corruptions.
    for (int r = 0; r < 6; r++) begin
      fill_match();
      n = $urandom_range(0, DEPTH);
      for (int k = 0; k < 3; k++) begin
        int a;
        a = $urandom_range(0, DEPTH - 1);
        if ($urandom_range(0, 1) == 1) mem[a] = mem[a] ^ (32'h1 << $urandom_range(0, 31));
      end
      run_check(n, (r == 2) ? 2 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
